// File: rtl/program_loader_if.sv
// Byte-stream input and main-memory write bus of the boot program loader.
interface program_loader_if #(
  parameter int addr_width = 8,
  parameter int data_width = 16
);
  logic [7:0]            in_byte;
  logic                  in_valid;
  logic                  in_ready;
  logic [addr_width-1:0] ld_addr;
  logic [data_width-1:0] ld_data;
  logic                  ld_wr;

  modport master (output in_byte, in_valid, input in_ready, ld_addr, ld_data, ld_wr);
  modport slave  (input in_byte, in_valid, output in_ready, ld_addr, ld_data, ld_wr);
endinterface

// File: rtl/program_loader.sv
// Boot loader: parses a framed byte stream (count, big-endian words, XOR checksum),
// writes words to consecutive memory addresses and holds the CPU in reset until a good load.
module program_loader #(
  parameter int                    data_width = 16,
  parameter int                    addr_width = 8,
  parameter logic [addr_width-1:0] start_addr = '0
) (
  input  logic             clk,
  input  logic             rst,
  program_loader_if.slave  bus,
  input  logic             start,
  output logic             cpu_rst,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {
    S_COUNT, S_HI, S_LO, S_WRITE, S_CKSUM, S_DONE, S_ERR
  } state_t;

  state_t                state_reg, state_next;
  logic [7:0]            count_reg, count_next;
  logic [7:0]            idx_reg, idx_next;
  logic [7:0]            xsum_reg, xsum_next;
  logic [7:0]            hi_reg, hi_next;
  logic                  ld_wr_reg, ld_wr_next;
  logic [addr_width-1:0] ld_addr_reg, ld_addr_next;
  logic [data_width-1:0] ld_data_reg, ld_data_next;
  logic                  cpu_rst_reg, cpu_rst_next;
  logic                  done_reg, done_next;
  logic                  err_reg, err_next;
  logic                  in_ready;
  logic                  accept;
  logic [8:0]            idx_inc;

  assign in_ready = (state_reg == S_COUNT) || (state_reg == S_HI) ||
                    (state_reg == S_LO)    || (state_reg == S_CKSUM);
  assign accept   = bus.in_valid & in_ready;
  // Nine bits so that idx+1 compares correctly against a count of 255.
  assign idx_inc  = {1'b0, idx_reg} + 9'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= S_COUNT;
      count_reg   <= '0;
      idx_reg     <= '0;
      xsum_reg    <= '0;
      hi_reg      <= '0;
      ld_wr_reg   <= 1'b0;
      ld_addr_reg <= '0;
      ld_data_reg <= '0;
      cpu_rst_reg <= 1'b1;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      idx_reg     <= idx_next;
      xsum_reg    <= xsum_next;
      hi_reg      <= hi_next;
      ld_wr_reg   <= ld_wr_next;
      ld_addr_reg <= ld_addr_next;
      ld_data_reg <= ld_data_next;
      cpu_rst_reg <= cpu_rst_next;
      done_reg    <= done_next;
      err_reg     <= err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    count_next   = count_reg;
    idx_next     = idx_reg;
    xsum_next    = xsum_reg;
    hi_next      = hi_reg;
    ld_wr_next   = 1'b0;
    ld_addr_next = ld_addr_reg;
    ld_data_next = ld_data_reg;
    cpu_rst_next = cpu_rst_reg;
    done_next    = done_reg;
    err_next     = err_reg;
    unique case (state_reg)
      S_COUNT: if (accept) begin
        count_next = bus.in_byte;
        xsum_next  = bus.in_byte;
        state_next = (bus.in_byte == 8'd0) ? S_CKSUM : S_HI;
      end
      S_HI: if (accept) begin
        hi_next    = bus.in_byte;
        xsum_next  = xsum_reg ^ bus.in_byte;
        state_next = S_LO;
      end
      // Write strobe is registered here so it is high exactly for the WRITE cycle.
      S_LO: if (accept) begin
        xsum_next    = xsum_reg ^ bus.in_byte;
        ld_wr_next   = 1'b1;
        ld_addr_next = start_addr + addr_width'(idx_reg);
        ld_data_next = data_width'({hi_reg, bus.in_byte});
        state_next   = S_WRITE;
      end
      S_WRITE: begin
        idx_next   = idx_inc[7:0];
        state_next = (idx_inc < {1'b0, count_reg}) ? S_HI : S_CKSUM;
      end
      S_CKSUM: if (accept) begin
        if (bus.in_byte == xsum_reg) begin
          state_next   = S_DONE;
          done_next    = 1'b1;
          cpu_rst_next = 1'b0;
        end else begin
          state_next = S_ERR;
          err_next   = 1'b1;
        end
      end
      S_DONE, S_ERR: if (start) begin
        state_next   = S_COUNT;
        idx_next     = '0;
        xsum_next    = '0;
        done_next    = 1'b0;
        err_next     = 1'b0;
        cpu_rst_next = 1'b1;
      end
      default: state_next = S_COUNT;
    endcase
  end

  assign bus.in_ready = in_ready;
  assign bus.ld_wr    = ld_wr_reg;
  assign bus.ld_addr  = ld_addr_reg;
  assign bus.ld_data  = ld_data_reg;
  assign cpu_rst      = cpu_rst_reg;
  assign done         = done_reg;
  assign err          = err_reg;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: two instances (base 00 and FE) see the same random frames.
module tb_program_loader;
  localparam int         AW        = 8;
  localparam int         DW        = 16;
  localparam logic [7:0] WRAP_BASE = 8'hFE;

  typedef struct packed {
    logic [7:0]  a;
    logic [15:0] d;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] in_byte = 8'h00;
  logic       in_valid = 1'b0;
  logic       cpu_rst0, done0, err0, cpu_rst1, done1, err1;

  int         checks = 0;
  int         failures = 0;
  wr_t        q0[$];
  wr_t        q1[$];
  logic [7:0] payload[$];
  logic [15:0] mem0 [256];
  logic [15:0] mem1 [256];
  logic       prev_wr0 = 1'b0;
  logic       prev_wr1 = 1'b0;

  program_loader_if #(.addr_width(AW), .data_width(DW)) bus0 ();
  program_loader_if #(.addr_width(AW), .data_width(DW)) bus1 ();

  assign bus0.in_byte  = in_byte;
  assign bus0.in_valid = in_valid;
  assign bus1.in_byte  = in_byte;
  assign bus1.in_valid = in_valid;

  program_loader #(.data_width(DW), .addr_width(AW), .start_addr(8'h00)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave), .start(start),
    .cpu_rst(cpu_rst0), .done(done0), .err(err0)
  );
  program_loader #(.data_width(DW), .addr_width(AW), .start_addr(WRAP_BASE)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave), .start(start),
    .cpu_rst(cpu_rst1), .done(done1), .err(err1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory models capture writes on the edge that ends WRITE.
  always @(posedge clk) begin
    if (bus0.ld_wr) mem0[bus0.ld_addr] <= bus0.ld_data;
    if (bus1.ld_wr) mem1[bus1.ld_addr] <= bus1.ld_data;
  end

  // Monitor: every write strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    wr_t e;
    if (rst) begin
      prev_wr0 <= 1'b0;
      prev_wr1 <= 1'b0;
    end else begin
      if (bus0.ld_wr) begin
        check("wr_gap0", prev_wr0, 0);
        if (q0.size() == 0) check("unexpected_wr0_addr", bus0.ld_addr, 32'hFFFF_FFFF);
        else begin
          e = q0.pop_front();
          check("write0", {bus0.ld_addr, bus0.ld_data}, {e.a, e.d});
        end
      end
      if (bus1.ld_wr) begin
        check("wr_gap1", prev_wr1, 0);
        if (q1.size() == 0) check("unexpected_wr1_addr", bus1.ld_addr, 32'hFFFF_FFFF);
        else begin
          e = q1.pop_front();
          check("write1", {bus1.ld_addr, bus1.ld_data}, {e.a, e.d});
        end
      end
      prev_wr0 <= bus0.ld_wr;
      prev_wr1 <= bus1.ld_wr;
    end
  end

  function automatic logic rand_start(input bit en);
    return en && ($urandom_range(0, 2) == 0);
  endfunction

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input bit gaps, input bit rnd_start);
    int g;
    int t;
    if (gaps) begin
      g = $urandom_range(0, 3);
      for (int i = 0; i < g; i++) begin
        in_valid = 1'b0;
        start = rand_start(rnd_start);
        @(posedge clk); #1;
      end
    end
    in_byte = b;
    in_valid = 1'b1;
    t = 0;
    while (!bus0.in_ready && t < 20) begin
      start = rand_start(rnd_start);
      @(posedge clk); #1;
      t++;
    end
    if (!bus0.in_ready) check("ready_timeout", bus0.in_ready, 1);
    start = rand_start(rnd_start);
    @(posedge clk); #1;
    in_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic fill(input int nbytes);
    payload.delete();
    for (int i = 0; i < nbytes; i++) payload.push_back(8'($urandom_range(0, 255)));
  endtask

  // Sends one frame built from payload; expected writes come from the frame rules alone.
  task automatic run_frame(input logic [7:0] n, input logic [7:0] bad_mask, input bit gaps, input bit rnd_start);
    logic [7:0] xs;
    logic [7:0] c;
    bit         good;
    wr_t        e;
    xs = n;
    for (int i = 0; i < 2 * int'(n); i++) xs ^= payload[i];
    c = xs ^ bad_mask;
    good = (bad_mask == 8'h00);
    send_byte(n, gaps, rnd_start);
    for (int i = 0; i < int'(n); i++) begin
      send_byte(payload[2*i], gaps, rnd_start);
      send_byte(payload[2*i+1], gaps, rnd_start);
      e.d = {payload[2*i], payload[2*i+1]};
      e.a = 8'(i);
      q0.push_back(e);
      e.a = 8'(int'(WRAP_BASE) + i);
      q1.push_back(e);
    end
    send_byte(c, gaps, rnd_start);
    @(negedge clk);
    $display("frame n=%0d cksum=%02h good=%0d gaps=%0d", n, c, good, gaps);
    check("done", done0, good);
    check("err", err0, !good);
    check("cpu_rst", cpu_rst0, !good);
    check("done_wrap", done1, good);
    check("in_ready_end", bus0.in_ready, 0);
    check("pending_writes", q0.size() + q1.size(), 0);
    if (good) begin
      for (int i = 0; i < int'(n); i++) begin
        check("mem0", mem0[8'(i)], {payload[2*i], payload[2*i+1]});
        check("mem1", mem1[8'(int'(WRAP_BASE) + i)], {payload[2*i], payload[2*i+1]});
      end
    end
  endtask

  // Called at a falling edge; a byte offered alongside start must be ignored.
  task automatic rearm();
    start = 1'b1;
    in_byte = 8'hEE;
    in_valid = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    in_valid = 1'b0;
    check("rearm_ready", bus0.in_ready, 1);
    check("rearm_done", done0, 0);
    check("rearm_err", err0, 0);
    check("rearm_cpu_rst", cpu_rst0, 1);
    @(negedge clk);
  endtask

  initial begin
    wr_t e;
    logic [7:0] n;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    $display("reset idle");
    check("rst_cpu_rst", cpu_rst0, 1);
    check("rst_done", done0, 0);
    check("rst_err", err0, 0);
    check("rst_in_ready", bus0.in_ready, 1);
    check("rst_ld_wr", bus0.ld_wr, 0);
    check("rst_ld_addr1", bus1.ld_addr, 0);

    payload = '{8'h12, 8'h34, 8'hAB, 8'hCD};
    run_frame(8'd2, 8'h00, 1'b0, 1'b0);
    rearm();
    run_frame(8'd2, 8'h01, 1'b0, 1'b0);
    rearm();
    run_frame(8'd2, 8'h00, 1'b0, 1'b1);
    rearm();
    payload.delete();
    run_frame(8'd0, 8'h00, 1'b0, 1'b0);
    rearm();
    fill(6);
    run_frame(8'd3, 8'h00, 1'b0, 1'b0);
    rearm();

    for (int f = 0; f < 12; f++) begin
      n = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 2)) : 8'($urandom_range(1, 24));
      fill(2 * int'(n));
      run_frame(n, ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00,
                1'($urandom_range(0, 1)), 1'b1);
      rearm();
    end

    // Reset after the high byte of word 1: word 0 written, word 1 discarded.
    fill(4);
    @(posedge clk); #1;
    send_byte(8'd2, 1'b0, 1'b0);
    send_byte(payload[0], 1'b0, 1'b0);
    send_byte(payload[1], 1'b0, 1'b0);
    e.d = {payload[0], payload[1]};
    e.a = 8'h00;
    q0.push_back(e);
    e.a = WRAP_BASE;
    q1.push_back(e);
    send_byte(payload[2], 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    $display("reset mid-frame");
    check("midrst_in_ready", bus0.in_ready, 1);
    check("midrst_ld_wr", bus0.ld_wr, 0);
    check("midrst_ld_addr1", bus1.ld_addr, 0);
    check("midrst_ld_data1", bus1.ld_data, 0);
    check("midrst_cpu_rst", cpu_rst0, 1);
    check("midrst_done_err", {done0, err0, done1, err1}, 0);
    @(negedge clk);
    rst = 1'b0;
    check("midrst_pending", q0.size() + q1.size(), 0);
    fill(10);
    run_frame(8'd5, 8'h00, 1'b1, 1'b1);
    rearm();

    fill(510);
    run_frame(8'd255, 8'h00, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time program loader: the writing end of the main-memory interface whose reader is the processor's instruction fetch. It receives a framed byte stream (count, big-endian 16-bit words, XOR checksum) over a valid/ready handshake. It writes each assembled word into main memory at consecutive addresses and holds the processor in reset until a load completes with a good checksum. At top level, `ld_data`/`ld_addr`/`ld_wr` are muxed or ORed onto the memory `W_data`/`addr`/`wr` pins, and `cpu_rst` is ORed into the processor reset.

## Interface
- `data_width`, 16: memory word width; fixed at 16 (two bytes per word).
- `addr_width`, 8: memory address width.
- `start_addr`, 0: address of the first loaded word.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_byte`  in  8  stream byte.
- `in_valid`  in  1  `in_byte` valid.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `start`  in  1  single-cycle pulse; re-arms the loader from DONE or ERR.
- `ld_addr`  out  `addr_width`  memory write address.
- `ld_data`  out  `data_width`  memory write data.
- `ld_wr`  out  1  memory write enable, one cycle per word.
- `cpu_rst`  out  1  processor hold-in-reset.
- `done`  out  1  load completed, checksum good.
- `err`  out  1  load completed, checksum bad.

## Operation
- **Frame format:** byte `N` (word count, 0–255), then `2N` data bytes (high byte first per word), then checksum byte `C`.
- **Checksum rule:** `C` must equal the XOR of `N` and all `2N` data bytes.
- **Handshake:** a byte is accepted on a rising edge with `in_valid & in_ready`.
- **`in_ready`:** combinational from state; 1 in COUNT, HI, LO and CKSUM; 0 in WRITE, DONE and ERR.
- **States:**
  - COUNT: accept byte → latch `N` and init `xsum = byte`; go to HI, or to CKSUM if byte is 0.
  - HI: accept byte → latch high byte, XOR into `xsum`; go to LO.
  - LO: accept byte → latch low byte, XOR into `xsum`; go to WRITE.
  - WRITE: `ld_wr`=1 for this one cycle; `ld_addr = start_addr + idx`, `ld_data = {hi, lo}`. On exit increment `idx` and go to HI if `idx+1 < N`, else CKSUM.
  - CKSUM: accept byte → DONE if `byte == xsum`, else ERR.
  - DONE: `done`=1, `cpu_rst`=0. `start` → COUNT.
  - ERR: `err`=1, `cpu_rst`=1. `start` → COUNT.
- **Address arithmetic:** `start_addr + idx` is computed modulo `2^addr_width`, so addresses wrap silently.
- **`idx` width:** 8-bit word index; `N`=255 is the maximum count.
- **`start` handling:** `start` outside DONE/ERR is ignored. On re-arm, `idx`, `xsum`, `done` and `err` clear and `cpu_rst` asserts.
- **No rollback:** memory already written by a failed load is not restored; the processor stays held instead.
- **Reset:** `rst` asserted at any time (including mid-word or mid-frame) immediately forces:
  - state COUNT, `idx`=0, `xsum`=0;
  - `ld_wr`=0, `ld_addr`=0, `ld_data`=0;
  - `cpu_rst`=1, `done`=0, `err`=0.
  - Partially assembled words are discarded.

## Timing
- All outputs except `in_ready` are registered.
- **Reset values:**
  - `in_ready`=1 (state COUNT);
  - `ld_wr`=0, `ld_addr`=0, `ld_data`=0;
  - `cpu_rst`=1, `done`=0, `err`=0.
- **Per-word cost:** a word costs at least 3 cycles (HI accept, LO accept, WRITE); `in_ready` is low during WRITE.
- **Write cycle:** `ld_wr`, `ld_addr` and `ld_data` are valid in the same cycle. Memory captures them at the rising edge that ends WRITE.
- **Write-enable gap:** `ld_wr` is never high in two consecutive cycles.
- **Completion latency:** `done`/`err` rise, and `cpu_rst` falls on success, on the edge that accepts `C`. They are visible the cycle after acceptance.
- **Re-arm latency:** `start` in DONE/ERR takes effect on that edge; `in_ready`=1 the next cycle. Any byte offered in that same cycle is not accepted.
- **Stalls:** `in_valid` low in any accepting state stalls without state change; stalls of any length are legal.

## Test plan
- **Reset defaults:** reset, then idle 5 cycles → `cpu_rst`=1, `done`=0, `err`=0, `ld_wr` never asserted, `in_ready`=1.
- **Two-word load:** stream 02, 12, 34, AB, CD, C = 02^12^34^AB^CD = 42 →
  - `ld_wr` pulses at addr 00 data 1234, then addr 01 data ABCD;
  - then `done`=1, `cpu_rst`=0; memory readback matches.
- **Bad checksum:** same stream with C=43 → both writes occur, `err`=1, `done`=0, `cpu_rst` stays 1. Then pulse `start` and resend the good frame → `done`=1.
- **Empty frame and address wrap:**
  - Stream 00, 00 → no `ld_wr`; `done`=1 one cycle after C is accepted.
  - With `start_addr`=FE and N=3 → writes at FE, FF, 00.
- **Stalls and reset mid-frame:**
  - Random `in_valid` gaps → same writes as the no-gap run.
  - Assert `rst` after the HI byte of word 1 → outputs return to reset values immediately, no write for word 1; a fresh frame then loads correctly.
- **Ignored `start`:** pulse `start` in HI, LO, WRITE and CKSUM → no effect on state, `idx` or `xsum`.
